// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide scheduler and HI/LO owner for the pipelined core.
//
// An accepted mult/multu/div/divu computes its 64-bit result immediately and
// parks it in pending registers. The unit then stays busy for a fixed window
// of MULT_CYCLES or DIV_CYCLES cycles, and commits the result to HI/LO at the
// edge that closes the window. mthi/mtlo write HI/LO in one cycle when the
// unit is idle.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   E_MDUOp   E-stage op: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 mfhi, 8 mflo, anything else is no-op
//   E_Start   qualifies ops 1-4 in the cycle they sit in E
//   E_RS/E_RT forwarded operands
//   Req       exception/interrupt flush of the current E-stage op
//   D_IsMDU   D-stage instruction is an MDU op
//   Busy      unit occupied by a multiply/divide window
//   Stall     hold request to the D stage
//   HI/LO     architectural HI/LO
//   E_MDUOut  mfhi/mflo read data, zero for other ops
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        Req,
  input  logic        D_IsMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDUOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // 32x32 -> 64 product; signed mode sign-extends both operands so the low
  // 64 bits of the unsigned product are the two's-complement result.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Signed mode divides magnitudes and fixes the
  // signs afterwards: quotient truncates toward zero, remainder follows the
  // dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;
    q     = ma / mb;
    r     = ma % mb;
    q     = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
    r     = neg_a ? (~r + 32'd1) : r;
    return {r, q};
  endfunction

  state_t           state_r,   state_nxt_s;
  logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
  logic [31:0]      pend_hi_r, pend_hi_nxt_s;
  logic [31:0]      pend_lo_r, pend_lo_nxt_s;
  logic             pend_ok_r, pend_ok_nxt_s;   // clear for divide by zero: no commit
  logic [31:0]      hi_r,      hi_nxt_s;
  logic [31:0]      lo_r,      lo_nxt_s;
  logic             is_arith_s;
  logic [63:0]      res_s;

  assign is_arith_s = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);

  // Next-state logic: start accept, mthi/mtlo writes, countdown and commit.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_ok_nxt_s = pend_ok_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    res_s         = 64'd0;
    case (state_r)
      ST_IDLE: begin
        if (!Req && E_Start && is_arith_s) begin
          case (E_MDUOp)
            OP_MULT:  res_s = mul64(E_RS, E_RT, 1'b1);
            OP_MULTU: res_s = mul64(E_RS, E_RT, 1'b0);
            OP_DIV:   res_s = div64(E_RS, E_RT, 1'b1);
            OP_DIVU:  res_s = div64(E_RS, E_RT, 1'b0);
            default:  res_s = 64'd0;
          endcase
          pend_hi_nxt_s = res_s[63:32];
          pend_lo_nxt_s = res_s[31:0];
          if ((E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU)) begin
            cnt_nxt_s     = DIV_LOAD;
            pend_ok_nxt_s = (E_RT != 32'd0);
          end else begin
            cnt_nxt_s     = MULT_LOAD;
            pend_ok_nxt_s = 1'b1;
          end
          state_nxt_s = ST_BUSY;
        end else if (!Req && (E_MDUOp == OP_MTHI)) begin
          hi_nxt_s = E_RS;
        end else if (!Req && (E_MDUOp == OP_MTLO)) begin
          lo_nxt_s = E_RS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Starts and mt* seen here are ignored; Req cannot cancel an issued op.
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          if (pend_ok_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_ok_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_ok_r <= pend_ok_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
    end
  end

  // mfhi/mflo read port.
  always_comb begin
    case (E_MDUOp)
      OP_MFHI: E_MDUOut = hi_r;
      OP_MFLO: E_MDUOut = lo_r;
      default: E_MDUOut = 32'd0;
    endcase
  end

  assign Busy  = (state_r == ST_BUSY);
  assign Stall = D_IsMDU & (Busy | E_Start);
  assign HI    = hi_r;
  assign LO    = lo_r;

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: each accepted mult/div pushes its expected
// HI/LO and busy length; the entry is popped when Busy falls.
module tb_mdu_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        Req;
  logic        D_IsMDU;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUOut;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_err;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDUOp  (E_MDUOp),
    .E_Start  (E_Start),
    .E_RS     (E_RS),
    .E_RT     (E_RT),
    .Req      (Req),
    .D_IsMDU  (D_IsMDU),
    .Busy     (Busy),
    .Stall    (Stall),
    .HI       (HI),
    .LO       (LO),
    .E_MDUOut (E_MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; returns {HI, LO}.
  function automatic logic [63:0] model_arith(input logic [3:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt);
    longint a;
    longint b;
    longint q;
    longint r;
    logic [63:0] res;
    res = 64'd0;
    case (op)
      4'd1: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        res = 64'(a * b);
      end
      4'd2: res = {32'd0, rs} * {32'd0, rt};
      4'd3: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        res = {r[31:0], q[31:0]};
      end
      4'd4: begin
        a = longint'({32'd0, rs});
        b = longint'({32'd0, rt});
        q = a / b;
        r = a % b;
        res = {r[31:0], q[31:0]};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one E-stage op for a single cycle and update the model.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic req, input logic dmdu);
    logic        arith;
    logic [63:0] r;
    exp_t        e;
    arith   = (op >= 4'd1) && (op <= 4'd4);
    E_MDUOp = op;
    E_Start = arith;
    E_RS    = rs;
    E_RT    = rt;
    Req     = req;
    D_IsMDU = dmdu;
    #1;
    if (dmdu) check_val("stall_start", {63'd0, Stall}, 64'd1);
    tick();
    E_MDUOp = 4'd0;
    E_Start = 1'b0;
    Req     = 1'b0;
    if (!req && arith) begin
      e.cyc = (op <= 4'd2) ? 5 : 10;
      if (op >= 4'd3 && rt == 32'd0) begin
        e.hi = m_hi;
        e.lo = m_lo;
      end else begin
        r    = model_arith(op, rs, rt);
        e.hi = r[63:32];
        e.lo = r[31:0];
      end
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end else if (!req && op == 4'd5) begin
      m_hi = rs;
    end else if (!req && op == 4'd6) begin
      m_lo = rs;
    end
  endtask

  // Count busy cycles (bounded), optionally poke Req or illegal ops mid-window,
  // then pop the scoreboard and compare.
  task automatic wait_done(input string tag, input int req_at, input logic chk_stall,
                           input logic [1:0] inject);
    int   n;
    exp_t e;
    n = 0;
    while (Busy === 1'b1 && n < 60) begin
      n++;
      if (chk_stall) check_val({tag, "_stall_busy"}, {63'd0, Stall}, 64'd1);
      if (n == req_at) Req = 1'b1;
      if (inject[0] && n == 2) begin
        E_Start = 1'b1;
        E_MDUOp = 4'd3;
        E_RS    = 32'd100;
        E_RT    = 32'd3;
      end
      if (inject[1] && n == 3) begin
        E_MDUOp = 4'd5;
        E_RS    = 32'hDEADBEEF;
      end
      tick();
      Req     = 1'b0;
      E_Start = 1'b0;
      E_MDUOp = 4'd0;
    end
    if (chk_stall) check_val({tag, "_stall_idle"}, {63'd0, Stall}, 64'd0);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_cycles"}, 64'(n), 64'(e.cyc));
      check_val({tag, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
      check_val({tag, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    reset   = 1'b1;
    E_MDUOp = 4'd0;
    E_Start = 1'b0;
    E_RS    = 32'd0;
    E_RT    = 32'd0;
    Req     = 1'b0;
    D_IsMDU = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check_val("rst_busy",  {63'd0, Busy},  64'd0);
    check_val("rst_hi",    {32'd0, HI},    64'd0);
    check_val("rst_lo",    {32'd0, LO},    64'd0);
    check_val("rst_stall", {63'd0, Stall}, 64'd0);

    // mthi/mtlo, and mthi flushed by Req
    issue(4'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check_val("mthi_busy", {63'd0, Busy}, 64'd0);
    check_val("mthi_hi", {32'd0, HI}, {32'd0, m_hi});
    issue(4'd6, 32'hCAFEBABE, 32'd0, 1'b0, 1'b0);
    check_val("mtlo_busy", {63'd0, Busy}, 64'd0);
    check_val("mtlo_lo", {32'd0, LO}, {32'd0, m_lo});
    check_val("mtlo_hi_kept", {32'd0, HI}, {32'd0, m_hi});
    issue(4'd5, 32'h55555555, 32'd0, 1'b1, 1'b0);
    check_val("mthi_req_hi", {32'd0, HI}, {32'd0, m_hi});

    // read port
    E_MDUOp = 4'd7; #1;
    check_val("mfhi_out", {32'd0, E_MDUOut}, {32'd0, m_hi});
    E_MDUOp = 4'd5; #1;
    check_val("other_out", {32'd0, E_MDUOut}, 64'd0);
    E_MDUOp = 4'd0;

    // signed / unsigned multiply
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    wait_done("mult", 0, 1'b0, 2'b01);
    issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    wait_done("multu", 0, 1'b0, 2'b00);

    // signed divide with D-stage stall window, then mflo/mfhi
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    wait_done("div", 0, 1'b1, 2'b00);
    D_IsMDU = 1'b0;
    E_MDUOp = 4'd8; #1;
    check_val("mflo_after_div", {32'd0, E_MDUOut}, {32'd0, m_lo});
    E_MDUOp = 4'd7; #1;
    check_val("mfhi_after_div", {32'd0, E_MDUOut}, {32'd0, m_hi});
    E_MDUOp = 4'd0;

    // divide by zero keeps HI/LO; mthi during the window is ignored
    issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_done("divu0", 0, 1'b0, 2'b10);

    // overflow case and a positive/negative mix
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_done("div_ovf", 0, 1'b0, 2'b00);
    issue(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    wait_done("div_mix", 0, 1'b0, 2'b00);
    issue(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    wait_done("divu", 0, 1'b0, 2'b00);

    // start flushed by Req: never busy
    issue(4'd1, 32'd11, 32'd13, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_val("req_start_busy", {63'd0, Busy}, 64'd0);
      tick();
    end
    check_val("req_start_hi", {32'd0, HI}, {32'd0, m_hi});
    check_val("req_start_lo", {32'd0, LO}, {32'd0, m_lo});

    // Req mid-window does not cancel
    issue(4'd1, 32'd1234, 32'd5678, 1'b0, 1'b0);
    wait_done("req_mid", 3, 1'b0, 2'b00);

    // E_Start with a non-arith op: no-op, stall still follows the formula
    E_MDUOp = 4'd9;
    E_Start = 1'b1;
    D_IsMDU = 1'b1;
    #1;
    check_val("bad_op_stall", {63'd0, Stall}, 64'd1);
    tick();
    E_Start = 1'b0;
    E_MDUOp = 4'd0;
    D_IsMDU = 1'b0;
    check_val("bad_op_busy", {63'd0, Busy}, 64'd0);

    // reset in busy cycle 2 aborts with no commit
    issue(4'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    check_val("rstmid_busy1", {63'd0, Busy}, 64'd1);
    tick();
    reset = 1'b1;
    #1;
    check_val("rstmid_busy", {63'd0, Busy}, 64'd0);
    check_val("rstmid_hi", {32'd0, HI}, 64'd0);
    check_val("rstmid_lo", {32'd0, LO}, 64'd0);
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_val("rstmid_late_busy", {63'd0, Busy}, 64'd0);
    check_val("rstmid_late_hi", {32'd0, HI}, 64'd0);
    check_val("rstmid_late_lo", {32'd0, LO}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
